// File: rtl/hash_request_scheduler.sv
// hash_request_scheduler: round-robin serializer of requester ops onto a hash table controller; define HASH_SCHED_STATS_EN for op/failure counters
module hash_request_scheduler #(
  parameter int KEY_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 2,
  parameter int MEM_LATENCY = 1,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [2*NUM_REQ-1:0]             req_op_i,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]     req_key_i,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]    req_data_i,
  output logic [1:0]                       ctrl_op_o,
  output logic [KEY_WIDTH-1:0]             ctrl_key_o,
  output logic [DATA_WIDTH-1:0]            ctrl_data_o,
  output logic                             ctrl_clk_en_o,
  input  logic [DATA_WIDTH-1:0]            ctrl_read_data_i,
  input  logic                             ctrl_no_deletion_target_i,
  input  logic                             ctrl_no_write_space_i,
  input  logic                             ctrl_no_element_found_i,
  input  logic                             ctrl_key_already_present_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [ID_W-1:0]                  rsp_id_o,
  output logic [DATA_WIDTH-1:0]            rsp_data_o,
  output logic [2:0]                       rsp_status_o
`ifdef HASH_SCHED_STATS_EN
  ,
  output logic [15:0]                      stat_ops_o,
  output logic [15:0]                      stat_fail_o
`endif
);
  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT, RESPOND} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, gnt_id, cand;
  logic gnt_valid, hs;
  logic [1:0] op_q, lat_cnt;
  logic [2:0] status_n;
  // round-robin search starting at rr_ptr; lowest offset wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_id = cand;
      end
    end
  end
  assign hs = state == IDLE && gnt_valid;
  assign status_n = ctrl_key_already_present_i ? 3'b011 :
                    ctrl_no_write_space_i      ? 3'b010 :
                    ctrl_no_deletion_target_i  ? 3'b100 :
                    ctrl_no_element_found_i    ? 3'b001 : 3'b000;
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next state; outputs gated by reset so an aborted request never reaches the controller
  always_comb begin
    state_n = state == IDLE    ? (hs ? (req_op_i[2*int'(gnt_id) +: 2] == 2'b00 ? RESPOND : LOOKUP) : IDLE) :
              state == LOOKUP  ? (lat_cnt == 2'(MEM_LATENCY - 1) ? COMMIT : LOOKUP) :
              state == COMMIT  ? RESPOND :
                                 (rsp_ready_i ? IDLE : RESPOND);
    req_ready_o = (!reset && hs) ? NUM_REQ'(1) << gnt_id : '0;
    ctrl_op_o = (!reset && state == COMMIT) ? op_q : 2'b00;
    ctrl_clk_en_o = !reset && state == COMMIT;
    rsp_valid_o = !reset && state == RESPOND;
  end
  // request latch, latency counter and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      op_q <= 2'b00;
      lat_cnt <= 2'd0;
      ctrl_key_o <= '0;
      ctrl_data_o <= '0;
      rsp_id_o <= '0;
      rsp_data_o <= '0;
      rsp_status_o <= 3'b000;
    end else begin
      if (hs) begin
        rr_ptr <= gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
        op_q <= req_op_i[2*int'(gnt_id) +: 2];
        ctrl_key_o <= req_key_i[KEY_WIDTH*int'(gnt_id) +: KEY_WIDTH];
        ctrl_data_o <= req_data_i[DATA_WIDTH*int'(gnt_id) +: DATA_WIDTH];
        rsp_id_o <= gnt_id;
        rsp_data_o <= '0;
        rsp_status_o <= 3'b000;
        lat_cnt <= 2'd0;
      end
      if (state == LOOKUP) lat_cnt <= lat_cnt + 2'd1;
      if (state == COMMIT) begin
        rsp_data_o <= op_q == 2'b01 ? ctrl_read_data_i : '0;
        rsp_status_o <= status_n;
      end
    end
  end
`ifdef HASH_SCHED_STATS_EN
  // saturating commit and failure counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops_o <= '0;
      stat_fail_o <= '0;
    end else if (state == COMMIT) begin
      if (stat_ops_o != 16'hFFFF) stat_ops_o <= stat_ops_o + 16'd1;
      if (stat_fail_o != 16'hFFFF && status_n != 3'b000) stat_fail_o <= stat_fail_o + 16'd1;
    end
  end
`endif
endmodule

// File: doc/hash_request_scheduler.md
HASH_REQUEST_SCHEDULER -- requirements
Module: hash_request_scheduler

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 2, key width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width in bits.
REQ-003 SHALL have parameter NUM_REQ, default 2, number of requesters (range 2..8).
REQ-004 SHALL have parameter MEM_LATENCY, default 1, cycles from key presentation to valid table read-out (range 1..4).
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: req_valid_i  in  NUM_REQ  per-requester request valid; req_ready_o  out  NUM_REQ  per-requester accept.
REQ-007 SHALL have ports: req_op_i  in  2xNUM_REQ  op per requester (00 nothing, 01 read, 10 write, 11 delete); req_key_i  in  KEY_WIDTHxNUM_REQ; req_data_i  in  DATA_WIDTHxNUM_REQ.
REQ-008 SHALL have ports: ctrl_op_o  out  2  op to table controller; ctrl_key_o  out  KEY_WIDTH; ctrl_data_o  out  DATA_WIDTH; ctrl_clk_en_o  out  1  controller/CAM clock enable.
REQ-009 SHALL have ports: ctrl_read_data_i  in  DATA_WIDTH; ctrl_no_deletion_target_i, ctrl_no_write_space_i, ctrl_no_element_found_i, ctrl_key_already_present_i  in  1 each.
REQ-010 SHALL have ports: rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_id_o  out  ceil(log2(NUM_REQ)); rsp_data_o  out  DATA_WIDTH; rsp_status_o  out  3.

Function
REQ-011 SHALL implement FSM states IDLE, LOOKUP, COMMIT, RESPOND.
REQ-012 IDLE: grant the first requester with req_valid_i high, searching round-robin from pointer rr_ptr; assert only that requester's req_ready_o; all req_ready_o low in other states.
REQ-013 On handshake in cycle T: latch id, op, key, data; rr_ptr <= (granted id + 1) mod NUM_REQ; if op = 00 go to RESPOND with status 000, else go to LOOKUP.
REQ-014 LOOKUP: hold ctrl_key_o/ctrl_data_o at latched values, ctrl_op_o = 00, for exactly MEM_LATENCY cycles (T+1..T+MEM_LATENCY), then COMMIT.
REQ-015 COMMIT (cycle T+MEM_LATENCY+1): drive ctrl_op_o = latched op for exactly one cycle, ctrl_clk_en_o = 1; capture ctrl_read_data_i and status flags; go to RESPOND.
REQ-016 ctrl_clk_en_o SHALL be 1 only in COMMIT, so controller/CAM state changes at most once per request.
REQ-017 Status encoding: 000 ok; 001 no_element_found; 010 no_write_space; 011 key_already_present; 100 no_deletion_target; priority if multiple flags set: 011 > 010 > 100 > 001.
REQ-018 rsp_data_o SHALL equal captured read data for read ops, zero otherwise.
REQ-019 RESPOND: rsp_valid_o = 1 from T+MEM_LATENCY+2; hold rsp_id_o/rsp_data_o/rsp_status_o stable until rsp_ready_i = 1; on handshake go to IDLE (next grant earliest following cycle).
REQ-020 Requester changing req_op_i/key/data after its handshake SHALL have no effect on the in-flight request.
REQ-021 Outside COMMIT, ctrl_op_o SHALL be 00; ctrl_key_o/ctrl_data_o SHALL hold latched values.

Reset
REQ-022 While reset = 1 at a clock edge: state IDLE, rr_ptr 0, req_ready_o 0, ctrl_op_o 00, ctrl_clk_en_o 0, ctrl_key_o/ctrl_data_o 0, rsp_valid_o 0, rsp_id_o/rsp_data_o/rsp_status_o 0.
REQ-023 Reset in any state SHALL abort the in-flight request with no controller write and no response.

Configuration
REQ-024 Macro HASH_SCHED_STATS_EN defined: add outputs stat_ops_o (16 bit, +1 per COMMIT) and stat_fail_o (16 bit, +1 per COMMIT with status != 000), both saturating at 0xFFFF, cleared by reset.
REQ-025 Macro HASH_SCHED_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-026 Reset then requester 0 write key 2 data 0xA5A5A5A5, MEM_LATENCY 1, rsp_ready_i 1 -> ctrl_op_o = 10 only at T+2, rsp_valid_o at T+3, id 0, status 000.
REQ-027 Both requesters valid continuously with reads -> grants alternate 0,1,0,1; no requester granted twice consecutively.
REQ-028 Read with ctrl_no_element_found_i = 1 in COMMIT -> status 001, rsp_data_o 0; with flag 0 and read data 0x12345678 -> status 000, data 0x12345678.
REQ-029 rsp_ready_i held 0 for 5 cycles in RESPOND -> rsp outputs stable, no req_ready_o asserted, ctrl_clk_en_o 0 throughout.
REQ-030 Reset asserted during LOOKUP -> no COMMIT cycle, no rsp_valid_o, next request granted from rr_ptr 0.
REQ-031 With HASH_SCHED_STATS_EN: 3 committed ops, one with key_already_present -> stat_ops_o 3, stat_fail_o 1; op 00 request leaves both unchanged.
